// File: rtl/lighthouse_emitter.sv
// lighthouse_emitter: V1-style base station pulse train on one pin.
// Encoded sync flash per frame, optional sweep, alternating X/Y axis.
module lighthouse_emitter #(
  parameter int FRAME_CYCLES = 400000,
  parameter int SYNC_BASE    = 3000,
  parameter int SYNC_STEP    = 500,
  parameter int SWEEP_WIDTH  = 480,
  parameter int MIN_GAP      = 1000,
  parameter int COUNT_BITS   = 19
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  enable,
  input  logic [COUNT_BITS-1:0] angle_x,
  input  logic [COUNT_BITS-1:0] angle_y,
  input  logic                  skip,
  input  logic                  data,
  output logic                  light,
  output logic                  axis,
  output logic                  frame_start,
  output logic                  data_taken,
  output logic                  sweep_skipped
);

  localparam int W = COUNT_BITS;

  localparam logic [W-1:0] LAST  = W'(FRAME_CYCLES - 1);
  localparam logic [W-1:0] BASE  = W'(SYNC_BASE);
  localparam logic [W-1:0] STEP  = W'(SYNC_STEP);
  localparam logic [W-1:0] ONE   = W'(1);
  localparam logic [W:0]   ONE_W = (W+1)'(1);
  localparam logic [W:0]   FRM_W = (W+1)'(FRAME_CYCLES);
  localparam logic [W:0]   GAP_W = (W+1)'(MIN_GAP);
  localparam logic [W:0]   SWP_W = (W+1)'(SWEEP_WIDTH);

  typedef enum logic [2:0] {
    IDLE,
    SYNC,
    GAP,
    SWEEP,
    TAIL
  } state_t;

  state_t state, state_d;

  logic [W-1:0] t, t_d;
  logic [W-1:0] angle_q;
  logic         skip_q, data_q;

  logic         first;
  logic         skip_e, data_e;
  logic [W-1:0] angle_e;
  logic [2:0]   code;
  logic [W-1:0] sync_len;
  logic [W:0]   sweep_end;
  logic         valid;
  logic         wrap;

  // On frame cycle 0 the live inputs are used; latched copies afterwards.
  assign first   = (state == SYNC) && (t == '0);
  assign skip_e  = first ? skip : skip_q;
  assign data_e  = first ? data : data_q;
  assign angle_e = first ? (axis ? angle_y : angle_x) : angle_q;

  assign code      = {skip_e, data_e, axis};
  assign sync_len  = BASE + STEP * W'(code);
  assign sweep_end = {1'b0, angle_e} + SWP_W - ONE_W;
  assign valid     = ({1'b0, angle_e} >= {1'b0, sync_len} + GAP_W)
                  && ({1'b0, angle_e} + SWP_W <= FRM_W);
  assign wrap      = (state != IDLE) && (t == LAST);

  // Next-state and frame counter; frame wrap overrides every phase.
  always_comb begin
    state_d = state;
    t_d     = t;
    unique case (state)
      IDLE: begin
        t_d = '0;
        if (enable) state_d = SYNC;
      end
      SYNC: begin
        t_d = t + ONE;
        if (t == sync_len - ONE) state_d = GAP;
      end
      GAP: begin
        t_d = t + ONE;
        if (valid && (t == angle_e - ONE)) state_d = SWEEP;
      end
      SWEEP: begin
        t_d = t + ONE;
        if ({1'b0, t} == sweep_end) state_d = TAIL;
      end
      TAIL: begin
        t_d = t + ONE;
      end
      default: begin
        state_d = IDLE;
        t_d     = '0;
      end
    endcase
    if (wrap) begin
      state_d = enable ? SYNC : IDLE;
      t_d     = '0;
    end
  end

  // State and counter registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      t     <= '0;
    end else begin
      state <= state_d;
      t     <= t_d;
    end
  end

  // Frame parameters held for the rest of the frame; axis flips on wrap.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      skip_q  <= 1'b0;
      data_q  <= 1'b0;
      angle_q <= '0;
      axis    <= 1'b0;
    end else begin
      if (first) begin
        skip_q  <= skip;
        data_q  <= data;
        angle_q <= angle_e;
      end
      if (wrap) axis <= ~axis;
    end
  end

  // Registered pin and strobes so the emitter never glitches.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      light         <= 1'b0;
      frame_start   <= 1'b0;
      data_taken    <= 1'b0;
      sweep_skipped <= 1'b0;
    end else begin
      light         <= (state == SYNC) || (state == SWEEP);
      frame_start   <= first;
      data_taken    <= first;
      sweep_skipped <= first && !valid;
    end
  end

endmodule

// File: tb/tb_lighthouse_emitter.sv
// tb_lighthouse_emitter: directed frames, expected frames queued,
// a monitor checks each frame from its frame_start strobe.
module tb_lighthouse_emitter;

  localparam int FC = 200;
  localparam int SW = 4;

  logic       clk = 1'b0;
  logic       reset;
  logic       enable;
  logic [7:0] angle_x;
  logic [7:0] angle_y;
  logic       skip;
  logic       data;
  logic       light;
  logic       axis;
  logic       frame_start;
  logic       data_taken;
  logic       sweep_skipped;

  lighthouse_emitter #(
    .FRAME_CYCLES(200),
    .SYNC_BASE(30),
    .SYNC_STEP(5),
    .SWEEP_WIDTH(4),
    .MIN_GAP(10),
    .COUNT_BITS(8)
  ) dut (
    .clk(clk),
    .reset(reset),
    .enable(enable),
    .angle_x(angle_x),
    .angle_y(angle_y),
    .skip(skip),
    .data(data),
    .light(light),
    .axis(axis),
    .frame_start(frame_start),
    .data_taken(data_taken),
    .sweep_skipped(sweep_skipped)
  );

  always #5 clk = ~clk;

  typedef struct {
    int ax;
    int sync;
    int valid;
    int start;
    int len;
    int b2b;
  } exp_t;

  typedef struct {
    bit s;
    bit d;
    int ang;
    int ax;
    int sync;
    int valid;
    int len;
    int b2b;
  } vec_t;

  exp_t q[$];
  vec_t v[14];

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string nm, input int act, input int req);
    n_cmp++;
    if (act != req) begin
      n_bad++;
      $display("FAIL %s: got %0d, want %0d (t=%0t)", nm, act, req, $time);
    end
  endtask

  task automatic apply(input vec_t e);
    exp_t x;
    skip = e.s;
    data = e.d;
    if (e.ax == 0) begin
      angle_x = 8'(e.ang);
      angle_y = 8'd5;
    end else begin
      angle_y = 8'(e.ang);
      angle_x = 8'd5;
    end
    x.ax    = e.ax;
    x.sync  = e.sync;
    x.valid = e.valid;
    x.start = e.ang;
    x.len   = e.len;
    x.b2b   = e.b2b;
    q.push_back(x);
  endtask

  task automatic wait_fs(input string nm);
    for (int k = 0; k < 600; k++) begin
      @(negedge clk);
      if (frame_start) return;
    end
    chk({nm, "_timeout"}, 1, 0);
  endtask

  // monitor
  int   cyc = 0;
  int   last_fs = -1000;
  exp_t cur;
  bit   coll = 1'b0;
  int   idx, first_bad, stray;
  int   e_l;

  always @(negedge clk) begin
    cyc++;
    if (reset) begin
      coll = 1'b0;
    end else begin
      if (frame_start) begin
        if (coll) begin
          chk("frame_cut", idx, cur.len);
          coll = 1'b0;
        end
        if (q.size() == 0) begin
          chk("unexpected_frame", 1, 0);
        end else begin
          cur = q.pop_front();
          chk("axis", int'(axis), cur.ax);
          chk("data_taken", int'(data_taken), 1);
          chk("sweep_skipped", int'(sweep_skipped), cur.valid ? 0 : 1);
          if (cur.b2b != 0) chk("fs_period", cyc - last_fs, FC);
          coll      = 1'b1;
          idx       = 0;
          first_bad = -1;
          stray     = 0;
        end
        last_fs = cyc;
      end else if (coll && (data_taken || sweep_skipped)) begin
        stray++;
      end
      if (coll) begin
        e_l = (idx < cur.sync) ||
              (cur.valid != 0 && idx >= cur.start &&
               idx < cur.start + SW) ? 1 : 0;
        if (int'(light) != e_l && first_bad < 0) first_bad = idx;
        idx++;
        if (idx == cur.len) begin
          chk("light_first_bad_t", first_bad, -1);
          chk("stray_strobe", stray, 0);
          coll = 1'b0;
        end
      end
    end
  end

  // stimulus
  int dark;

  initial begin
    v[0]  = '{1'b0, 1'b1, 100, 0, 40, 1, 200, 0};
    v[1]  = '{1'b0, 1'b0, 150, 1, 35, 1, 200, 1};
    v[2]  = '{1'b1, 1'b0,  59, 0, 50, 0, 200, 1};
    v[3]  = '{1'b1, 1'b1,  75, 1, 65, 1, 200, 1};
    v[4]  = '{1'b1, 1'b0,  60, 0, 50, 1, 200, 1};
    v[5]  = '{1'b0, 1'b1, 100, 1, 45, 1, 200, 1};
    v[6]  = '{1'b1, 1'b1,  69, 0, 60, 0, 200, 1};
    v[7]  = '{1'b0, 1'b0,   0, 1, 35, 0, 200, 1};
    v[8]  = '{1'b0, 1'b0, 196, 0, 30, 1, 200, 1};
    v[9]  = '{1'b0, 1'b0, 197, 1, 35, 0, 200, 1};
    v[10] = '{1'b0, 1'b1, 120, 0, 40, 1, 200, 1};
    v[11] = '{1'b1, 1'b0,  90, 1, 55, 1, 200, 0};
    v[12] = '{1'b0, 1'b0,  80, 0, 30, 1,  10, 1};
    v[13] = '{1'b0, 1'b1, 100, 0, 40, 1, 200, 0};

    reset   = 1'b1;
    enable  = 1'b0;
    skip    = 1'b0;
    data    = 1'b0;
    angle_x = '0;
    angle_y = '0;
    repeat (3) @(negedge clk);
    chk("rst_light", int'(light), 0);
    chk("rst_axis", int'(axis), 0);
    chk("rst_frame_start", int'(frame_start), 0);
    chk("rst_data_taken", int'(data_taken), 0);
    chk("rst_sweep_skipped", int'(sweep_skipped), 0);
    reset = 1'b0;
    repeat (5) @(negedge clk);
    chk("idle_light", int'(light), 0);

    apply(v[0]);
    enable = 1'b1;
    @(negedge clk);
    chk("en_latency_early", int'(frame_start), 0);
    @(negedge clk);
    chk("en_latency_fs", int'(frame_start), 1);
    chk("en_latency_light", int'(light), 1);
    apply(v[1]);

    for (int i = 1; i <= 9; i++) begin
      wait_fs("frame");
      apply(v[i+1]);
    end

    wait_fs("frame11");
    repeat (20) @(negedge clk);
    enable = 1'b0;
    repeat (200) @(negedge clk);
    dark = 0;
    for (int k = 0; k < 50; k++) begin
      @(negedge clk);
      if (light || frame_start) dark++;
    end
    chk("idle_dark", dark, 0);
    chk("idle_axis", int'(axis), 1);

    apply(v[11]);
    enable = 1'b1;
    wait_fs("frame12");
    apply(v[12]);
    wait_fs("frame13");
    repeat (10) @(negedge clk);
    chk("pre_reset_light", int'(light), 1);
    reset = 1'b1;
    #1;
    chk("async_reset_light", int'(light), 0);
    apply(v[13]);
    repeat (3) @(negedge clk);
    chk("reset_axis", int'(axis), 0);
    reset = 1'b0;
    wait_fs("frame14");
    enable = 1'b0;
    repeat (230) @(negedge clk);
    chk("queue_empty", q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, want finish");
    $fatal(1, "watchdog");
  end

endmodule
